// File: rtl/wb_mem_responder_pkg.sv
// Shared types and sizing helpers for the start/done memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_mem_responder_pkg;

  // Default configuration, also used as the top-level parameter defaults.
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 1024;
  localparam int unsigned DEF_LATENCY    = 2;

  // Wait counter is wide enough for the largest supported LATENCY (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Number of byte lanes on a DATA_WIDTH bus.
  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Word-index width for a DEPTH-word memory (never less than one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DEF_LANES = lane_count(DEF_DATA_WIDTH);
  localparam int unsigned DEF_IDX_W = idx_width(DEF_DEPTH);

endpackage

// File: rtl/wb_resp_mem.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
// Latency: write and read both take effect at the clock edge where we/re is high.
// Backpressure: none; one access per enabled cycle, caller sequences accesses.
//
// Ports: clk, arst (async active-low, clears rdata only), we/re/clr access
// strobes, sel byte enables, idx word index, wdata write word, rdata held read word.
module wb_resp_mem
  import wb_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                arst,
  input  logic                                we,
  input  logic                                re,
  input  logic                                clr,
  input  logic [lane_count(DATA_WIDTH)-1:0]   sel,
  input  logic [idx_width(DEPTH)-1:0]         idx,
  input  logic [DATA_WIDTH-1:0]               wdata,
  output logic [DATA_WIDTH-1:0]               rdata
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (sel[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read register only moves on a read completion; clr covers out-of-range reads.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/wb_mem_responder.sv
// On-chip memory responder for the CPU start/done bus with programmable wait states.
// Latency: accept at edge k gives o_done during cycle k+1+LATENCY; one IDLE cycle between done and next accept.
// Backpressure: initiator holds start until o_done; no request is accepted outside IDLE.
//
// Ports: clk, arst (async active-low), i_start_read/i_start_write request levels,
// i_addr byte address, i_write_sel byte enables, i_write_data write word,
// o_read_data read word (held until next read completes), o_done completion pulse.
// Build option: define WB_MEM_RESPONDER_ERR_EN to add o_err (out-of-range or
// both-starts-high flag, valid in the done cycle).
module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           DEPTH      = DEF_DEPTH,
  parameter int unsigned           LATENCY    = DEF_LATENCY,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic                              i_start_read,
  input  logic                              i_start_write,
  input  logic [ADDR_WIDTH-1:0]             i_addr,
  input  logic [lane_count(DATA_WIDTH)-1:0] i_write_sel,
  input  logic [DATA_WIDTH-1:0]             i_write_data,
  output logic [DATA_WIDTH-1:0]             o_read_data,
  output logic                              o_done
`ifdef WB_MEM_RESPONDER_ERR_EN
  ,
  output logic                              o_err
`endif
);

  localparam int unsigned LANES      = lane_count(DATA_WIDTH);
  localparam int unsigned IDX_W      = idx_width(DEPTH);
  localparam int unsigned LANE_SHIFT = $clog2(LANES);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(DEPTH * LANES);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_t                  state;
  logic [CNT_W-1:0]        wait_cnt;
  op_t                     lat_op;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [LANES-1:0]        lat_sel;
  logic [DATA_WIDTH-1:0]   lat_wdata;

  logic                    start_any;
  op_t                     cur_op;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LANES-1:0]        cur_sel;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    cur_oor;
  logic [IDX_W-1:0]        word_idx;
  logic                    commit;

  assign start_any = i_start_read | i_start_write;

  // With zero wait states the commit happens on the accept edge itself, so the
  // access has to be steered from the live inputs while still in IDLE.
  always_comb begin
    cur_op    = lat_op;
    cur_addr  = lat_addr;
    cur_sel   = lat_sel;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_op    = i_start_write ? OP_WRITE : OP_READ;
      cur_addr  = i_addr;
      cur_sel   = i_write_sel;
      cur_wdata = i_write_data;
    end
  end

  // An address below BASE_ADDR wraps to a huge offset, so one compare catches
  // both ends of the window. Sub-word address bits fall off in the slice.
  assign offset   = cur_addr - BASE_ADDR;
  assign cur_oor  = (offset >= SPAN);
  assign word_idx = offset[LANE_SHIFT +: IDX_W];

  // commit marks the edge that enters RESP: memory access and done both key off it.
  always_comb begin
    commit = 1'b0;
    case (state)
      IDLE:    commit = start_any && (LATENCY == 0);
      WAIT:    commit = (wait_cnt == LAST_CNT);
      default: commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      o_done    <= 1'b0;
      lat_op    <= OP_READ;
      lat_addr  <= '0;
      lat_sel   <= '0;
      lat_wdata <= '0;
    end else begin
      o_done <= commit;
      case (state)
        IDLE: begin
          if (start_any) begin
            lat_op    <= cur_op;
            lat_addr  <= i_addr;
            lat_sel   <= i_write_sel;
            lat_wdata <= i_write_data;
            wait_cnt  <= '0;
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAST_CNT) begin
            wait_cnt <= '0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_MEM_RESPONDER_ERR_EN
  logic lat_both;
  logic cur_both;

  assign cur_both = (state == IDLE) ? (i_start_read & i_start_write) : lat_both;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      lat_both <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err <= commit && (cur_oor || cur_both);
      if (state == IDLE && start_any) begin
        lat_both <= i_start_read & i_start_write;
      end
    end
  end
`endif

  wb_resp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .arst  (arst),
    .we    (commit && (cur_op == OP_WRITE) && !cur_oor),
    .re    (commit && (cur_op == OP_READ)  && !cur_oor),
    .clr   (commit && (cur_op == OP_READ)  &&  cur_oor),
    .sel   (cur_sel),
    .idx   (word_idx),
    .wdata (cur_wdata),
    .rdata (o_read_data)
  );

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

  logic clk;
  logic arst;

  // Instance a: LATENCY=2, instance b: LATENCY=0. Both 64 words at base 0.
  logic        a_rd, a_wr, a_done;
  logic [31:0] a_addr, a_wd, a_rdat;
  logic [3:0]  a_sel;
  logic        b_rd, b_wr, b_done;
  logic [31:0] b_addr, b_wd, b_rdat;
  logic [3:0]  b_sel;
`ifdef WB_MEM_RESPONDER_ERR_EN
  logic        a_err, b_err;
`endif

  int tests;
  int fails;

  logic [31:0] model [64];

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  wb_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(2), .BASE_ADDR(32'h0)
  ) u_dut_a (
    .clk(clk), .arst(arst),
    .i_start_read(a_rd), .i_start_write(a_wr), .i_addr(a_addr),
    .i_write_sel(a_sel), .i_write_data(a_wd),
    .o_read_data(a_rdat), .o_done(a_done)
`ifdef WB_MEM_RESPONDER_ERR_EN
    , .o_err(a_err)
`endif
  );

  wb_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(0), .BASE_ADDR(32'h0)
  ) u_dut_b (
    .clk(clk), .arst(arst),
    .i_start_read(b_rd), .i_start_write(b_wr), .i_addr(b_addr),
    .i_write_sel(b_sel), .i_write_data(b_wd),
    .o_read_data(b_rdat), .o_done(b_done)
`ifdef WB_MEM_RESPONDER_ERR_EN
    , .o_err(b_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic rd, input logic wr,
                       input logic [31:0] ad, input logic [3:0] sl, input logic [31:0] wd);
    if (which == 0) begin
      a_rd = rd; a_wr = wr; a_addr = ad; a_sel = sl; a_wd = wd;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = ad; b_sel = sl; b_wd = wd;
    end
  endtask

  // Called at a negedge with the DUT idle. Holds start until done, then drops it.
  task automatic run_txn(input int which, input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [3:0] sl, input logic [31:0] wd,
                         input bit do_chk, input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_err, input string nm);
    int          cyc;
    bit          seen;
    logic [31:0] got_rd;
    logic        got_err;
    cyc  = 0;
    seen = 0;
    got_err = 1'b0;
    drive(which, rd, wr, ad, sl, wd);
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if ((which == 0) ? a_done : b_done) seen = 1;
    end
    got_rd = (which == 0) ? a_rdat : b_rdat;
`ifdef WB_MEM_RESPONDER_ERR_EN
    got_err = (which == 0) ? a_err : b_err;
`endif
    drive(which, 1'b0, 1'b0, ad, sl, wd);
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, cyc);
    end else if (do_chk) begin
      chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({nm, " rdata"}, got_rd, exp_rd);
`ifdef WB_MEM_RESPONDER_ERR_EN
      chk({nm, " err"}, {31'b0, got_err}, {31'b0, exp_err});
`else
      if (got_err !== exp_err && exp_err === 1'bx) chk({nm, " err"}, 32'd0, 32'd1);
`endif
      @(negedge clk);
      chk({nm, " done width"}, {31'b0, (which == 0) ? a_done : b_done}, 32'd0);
      chk({nm, " rdata held"}, (which == 0) ? a_rdat : b_rdat, exp_rd);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int          beat, gap, cyc;
    bit          pend;
    logic [31:0] exp_word;

    tests = 0;
    fails = 0;
    arst  = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h20,  4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h20,  4'h4, 32'h00AA_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h20,  4'h0, 32'h0,         32'h11AA_3344, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h28,  4'hF, 32'hCAFE_F00D, 32'h11AA_3344, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h28,  4'h1, 32'h0000_00EE, 32'h11AA_3344, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h2B,  4'h0, 32'h0,         32'hCAFE_F0EE, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h13,  4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h100, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   4'h0, 32'h0,         32'hA5A5_0000, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'h24,  4'h2, 32'h0000_7700, 32'hA5A5_0000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h24,  4'h0, 32'h0,         32'hA5A5_7709, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h1FC, 4'h0, 32'h0,         32'h0000_0000, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset a done", {31'b0, a_done}, 32'd0);
    chk("reset a rdata", a_rdat, 32'd0);
    chk("reset b done", {31'b0, b_done}, 32'd0);
    chk("reset b rdata", b_rdat, 32'd0);
    arst = 1'b1;
    @(negedge clk);

    // Preload every word of instance a with a known pattern
    for (int i = 0; i < 64; i++) begin
      model[i] = 32'hA5A5_0000 | 32'(i);
      run_txn(0, 1'b0, 1'b1, 32'(i * 4), 4'hF, model[i], 1'b0, 3, 32'h0, 1'b0, "preload");
    end

    // Directed vector table on the LATENCY=2 instance
    for (int i = 0; i < 15; i++) begin
      run_txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].sel, vecs[i].wd,
              1'b1, 3, vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
      if (vecs[i].wr && vecs[i].addr < 32'h100) begin
        for (int b = 0; b < 4; b++) begin
          if (vecs[i].sel[b]) model[vecs[i].addr[7:2]][b*8 +: 8] = vecs[i].wd[b*8 +: 8];
        end
      end
    end

    // Every word must match the model: out-of-range write must not alias anywhere
    for (int i = 0; i < 64; i++) begin
      run_txn(0, 1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b1, 3, model[i], 1'b0,
              $sformatf("scan%0d", i));
    end

    // Burst of 8 reads, start held, address advancing the cycle after each done
    beat = 0; gap = 0; cyc = 0; pend = 0;
    drive(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    while (beat < 8 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (pend) begin
        a_addr = 32'h40 + 32'(beat * 4);
        pend = 0;
      end
      if (a_done) begin
        exp_word = 32'hA5A5_0010 + 32'(beat);
        chk($sformatf("burst beat%0d data", beat), a_rdat, exp_word);
        if (beat > 0) chk($sformatf("burst beat%0d gap", beat), 32'(gap), 32'd3);
        gap = 0;
        beat++;
        pend = 1;
        if (beat == 8) a_rd = 1'b0;
      end else begin
        gap++;
      end
    end
    a_rd = 1'b0;
    chk("burst beats", 32'(beat), 32'd8);
    @(negedge clk);

    // Zero-latency instance, including both-starts-high and out-of-range
    run_txn(1, 1'b0, 1'b1, 32'h30,  4'hF, 32'h5566_7788, 1'b1, 1, 32'h0000_0000, 1'b0, "b wr");
    run_txn(1, 1'b1, 1'b0, 32'h30,  4'h0, 32'h0,         1'b1, 1, 32'h5566_7788, 1'b0, "b rd");
    run_txn(1, 1'b1, 1'b1, 32'h30,  4'hF, 32'h99AA_BBCC, 1'b1, 1, 32'h5566_7788, 1'b1, "b both");
    run_txn(1, 1'b1, 1'b0, 32'h30,  4'h0, 32'h0,         1'b1, 1, 32'h99AA_BBCC, 1'b0, "b rd2");
    run_txn(1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,         1'b1, 1, 32'h0000_0000, 1'b1, "b oor");
    run_txn(1, 1'b1, 1'b0, 32'h31,  4'h0, 32'h0,         1'b1, 1, 32'h99AA_BBCC, 1'b0, "b rd3");

    // Reset during WAIT abandons a write to word 8
    drive(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("arst a done", {31'b0, a_done}, 32'd0);
    chk("arst a rdata", a_rdat, 32'd0);
    chk("arst b rdata", b_rdat, 32'd0);
    a_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arst held done", {31'b0, a_done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    chk("post arst idle done", {31'b0, a_done}, 32'd0);
    run_txn(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 3, model[8], 1'b0, "post arst rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Responder (target) end of the CPU's start/done bus: the CPU raises start_read/start_write with address, byte select and write data, and waits for a one-cycle done pulse.
- Block holds a word-organised on-chip memory and answers single accesses and the CPU's back-to-back 8-beat cache-line sequences, with a programmable number of wait states.
- Sits between the CPU top and simulation/FPGA memory; replaces an external bus slave.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, bus data width; multiple of 8.
- DEPTH, 1024, number of DATA_WIDTH words in memory; power of two.
- LATENCY, 2, wait cycles inserted before done; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*DATA_WIDTH/8 aligned.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  reset; asynchronous assert, active-low.
- i_start_read  in  1  read request level; held until done.
- i_start_write  in  1  write request level; held until done.
- i_addr  in  ADDR_WIDTH  byte address; word index = (i_addr-BASE_ADDR)>>log2(DATA_WIDTH/8).
- i_write_sel  in  DATA_WIDTH/8  byte enables for write.
- i_write_data  in  DATA_WIDTH  write data, lanes already aligned by the initiator.
- o_read_data  out  DATA_WIDTH  read data; valid while o_done=1, held afterwards.
- o_done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (arst=0): state IDLE, o_done=0, o_read_data=0, wait counter=0. Memory contents are not reset. Reset mid-transaction abandons it. A write that has not yet reached its commit edge is lost.
- FSM states:
  - IDLE: at a clock edge with start_read|start_write=1, latch addr, sel, wdata and op. Go to WAIT if LATENCY>0, else RESP.
  - WAIT: counter counts up from 0. Leave for RESP at the edge where counter==LATENCY-1.
  - RESP: o_done=1 for exactly this cycle, then IDLE.
- Timing: request accepted at edge k gives o_done high during cycle k+1+LATENCY.
- Minimum spacing is one IDLE cycle between done and the next accept. The CPU's start stays high through a burst, and the next beat's address appears the cycle after done. The IDLE sample therefore sees the updated address.
- Commit: memory write (byte lanes where sel=1) and memory read into o_read_data both happen at the edge entering RESP. A read issued immediately after a write to the same word returns the new data.
- Both starts high at accept: write wins, read is ignored for that transaction.
- Start dropping during WAIT: the latched transaction still completes and done is still issued.
- Out of range (word index >= DEPTH, or addr < BASE_ADDR): write is discarded, read returns 0, done is issued normally. Low address bits below word size are ignored.
- o_read_data changes only on read completion.

Optional Feature:
- Macro WB_MEM_RESPONDER_ERR_EN.
- Defined: adds output o_err (1 bit, reset 0), high only in the RESP cycle of an out-of-range or both-starts-high transaction.
- Undefined: port absent, and both error cases behave silently as above.

Decomposition:
- Package wb_mem_responder_pkg:
  - state enum (IDLE, WAIT, RESP).
  - byte-lane count and word-index width localparams as functions of DATA_WIDTH/DEPTH.
  - op enum (OP_READ, OP_WRITE).
- Sub-module wb_resp_mem: single-port synchronous RAM, byte-enable write, registered read, one port used per access. FSM and counter stay in the top.

Test Plan:
- LATENCY=2: write 32'hDEAD_BEEF, sel 4'hF, addr 0x10. Done goes high exactly 3 cycles after accept. A following read of 0x10 returns 32'hDEAD_BEEF with done.
- Byte write: word 0x20 = 32'h1122_3344, then write sel 4'h4, data 32'h00AA_0000. Read of 0x20 returns 32'h11AA_3344.
- Burst: start_read held, addr 0x40..0x5C advancing after each done. Eight done pulses arrive, each separated by LATENCY+1 idle/wait cycles, and the data matches the preloaded words.
- LATENCY=0: a read is done 1 cycle after accept. Both starts high writes and does not update o_read_data; with the macro defined, o_err=1 in that cycle.
- Out of range: read at BASE_ADDR+4*DEPTH returns 0 with done. A write there leaves all memory words unchanged.
- arst pulsed low during WAIT: o_done stays 0, FSM returns to IDLE, o_read_data=0. The next request completes normally with correct latency.
